// File: rtl/regfile_scoreboard.sv
// Register file with same-cycle write bypass, a HI/LO pair and a pending-write scoreboard.
// Define REGFILE_R0_ZERO_EN to hard-wire register 0 to zero and exclude it from the scoreboard.
module regfile_scoreboard #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [AW-1:0]      raddr_a,
    input  logic [AW-1:0]      raddr_b,
    output logic [WIDTH-1:0]   rdata_a,
    output logic [WIDTH-1:0]   rdata_b,
    input  logic               hilo_we,
    input  logic [2*WIDTH-1:0] hilo_wdata,
    output logic [WIDTH-1:0]   hi_out,
    output logic [WIDTH-1:0]   lo_out,
    input  logic               busy_set,
    input  logic [AW-1:0]      busy_addr,
    output logic               busy_a,
    output logic               busy_b,
    output logic [DEPTH-1:0]   pending,
    output logic               wr_conflict
);

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic             conflict_q;
    logic             conflict_d;
    logic             wr_en;
    logic             set_en;
    logic             clr_hit;

    // With R0 hard-wired, address 0 writes vanish entirely, which also kills its bypass and clear.
    assign wr_en   = we && !(R0_ZERO && (waddr == '0));
    assign set_en  = busy_set && !(R0_ZERO && (busy_addr == '0));
    assign clr_hit = wr_en && (waddr == busy_addr);

    assign rdata_a = (wr_en && (waddr == raddr_a)) ? wdata : regs[raddr_a];
    assign rdata_b = (wr_en && (waddr == raddr_b)) ? wdata : regs[raddr_b];

    assign busy_a      = pend_q[raddr_a];
    assign busy_b      = pend_q[raddr_b];
    assign pending     = pend_q;
    assign wr_conflict = conflict_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

    // Set is applied after clear so a colliding issue keeps the register marked pending.
    always_comb begin
        pend_d = pend_q;
        if (wr_en) begin
            pend_d[waddr] = 1'b0;
        end
        if (set_en) begin
            pend_d[busy_addr] = 1'b1;
        end
    end

    assign conflict_d = set_en && pend_q[busy_addr] && !clr_hit;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hi_q       <= '0;
            lo_q       <= '0;
            pend_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            if (hilo_we) begin
                hi_q <= hilo_wdata[2*WIDTH-1:WIDTH];
                lo_q <= hilo_wdata[WIDTH-1:0];
            end
            pend_q     <= pend_d;
            conflict_q <= conflict_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a per-cycle vector table plus reset and readback sequences.
module tb_regfile_scoreboard;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0 = 1'b1;
`else
    localparam bit R0 = 1'b0;
`endif

    localparam logic [31:0] R0V = R0 ? 32'h0 : 32'h1234_5678;
    localparam logic        R0B = R0 ? 1'b0 : 1'b1;
    localparam logic [15:0] R0P = R0 ? 16'h0080 : 16'h0081;
    localparam logic        R0C = R0 ? 1'b0 : 1'b1;
    localparam logic [63:0] HL  = 64'h0000_0001_FFFF_FFFE;
    localparam logic [31:0] HI1 = 32'h0000_0001;
    localparam logic [31:0] LO1 = 32'hFFFF_FFFE;
    localparam logic [31:0] DB  = 32'hDEAD_BEEF;

    logic        clk;
    logic        clr;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  raddr_a;
    logic [3:0]  raddr_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        hilo_we;
    logic [63:0] hilo_wdata;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy_set;
    logic [3:0]  busy_addr;
    logic        busy_a;
    logic        busy_b;
    logic [15:0] pending;
    logic        wr_conflict;

    int errors = 0;
    int checks = 0;

    regfile_scoreboard dut (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .hilo_we(hilo_we), .hilo_wdata(hilo_wdata), .hi_out(hi_out), .lo_out(lo_out),
        .busy_set(busy_set), .busy_addr(busy_addr), .busy_a(busy_a), .busy_b(busy_b),
        .pending(pending), .wr_conflict(wr_conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        hwe;
        logic [63:0] hwd;
        logic        bs;
        logic [3:0]  ba;
        logic [31:0] e_ra;
        logic [31:0] e_rb;
        logic        e_ba;
        logic        e_bb;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic [15:0] e_pend;
        logic        e_conf;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0;
        hilo_we = 1'b0; hilo_wdata = '0;
        busy_set = 1'b0; busy_addr = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Each row: inputs for one cycle, combinational outputs seen with those inputs,
        // and registered outputs resulting from all previous rows.
        vecs[0]  = '{1'b1, 4'd5, DB,            4'd5, 4'd0, 1'b0, 64'h0, 1'b0, 4'd0, DB,        32'h0,     1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 4'd0, 32'h0,         4'd5, 4'd5, 1'b0, 64'h0, 1'b0, 4'd0, DB,        DB,        1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 4'd0, 32'h0,         4'd3, 4'd5, 1'b0, 64'h0, 1'b1, 4'd3, 32'h0,     DB,        1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 4'd0, 32'h0,         4'd3, 4'd5, 1'b0, 64'h0, 1'b0, 4'd0, 32'h0,     DB,        1'b1, 1'b0, 32'h0, 32'h0, 16'h0008, 1'b0};
        vecs[4]  = '{1'b0, 4'd0, 32'h0,         4'd3, 4'd5, 1'b0, 64'h0, 1'b0, 4'd0, 32'h0,     DB,        1'b1, 1'b0, 32'h0, 32'h0, 16'h0008, 1'b0};
        vecs[5]  = '{1'b1, 4'd3, 32'h33,        4'd3, 4'd3, 1'b0, 64'h0, 1'b0, 4'd0, 32'h33,    32'h33,    1'b1, 1'b1, 32'h0, 32'h0, 16'h0008, 1'b0};
        vecs[6]  = '{1'b0, 4'd0, 32'h0,         4'd3, 4'd5, 1'b0, 64'h0, 1'b0, 4'd0, 32'h33,    DB,        1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 1'b0};
        vecs[7]  = '{1'b1, 4'd7, 32'h77,        4'd7, 4'd3, 1'b0, 64'h0, 1'b1, 4'd7, 32'h77,    32'h33,    1'b0, 1'b0, 32'h0, 32'h0, 16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 4'd0, 32'h0,         4'd7, 4'd0, 1'b0, 64'h0, 1'b1, 4'd7, 32'h77,    32'h0,     1'b1, 1'b0, 32'h0, 32'h0, 16'h0080, 1'b0};
        vecs[9]  = '{1'b0, 4'd0, 32'h0,         4'd7, 4'd0, 1'b0, 64'h0, 1'b0, 4'd0, 32'h77,    32'h0,     1'b1, 1'b0, 32'h0, 32'h0, 16'h0080, 1'b1};
        vecs[10] = '{1'b0, 4'd0, 32'h0,         4'd5, 4'd7, 1'b1, HL,    1'b0, 4'd0, DB,        32'h77,    1'b0, 1'b1, 32'h0, 32'h0, 16'h0080, 1'b0};
        vecs[11] = '{1'b0, 4'd0, 32'h0,         4'd5, 4'd3, 1'b0, 64'h0, 1'b0, 4'd0, DB,        32'h33,    1'b0, 1'b0, HI1,   LO1,   16'h0080, 1'b0};
        vecs[12] = '{1'b1, 4'd9, 32'h99,        4'd9, 4'd7, 1'b0, 64'h0, 1'b1, 4'd7, 32'h99,    32'h77,    1'b0, 1'b1, HI1,   LO1,   16'h0080, 1'b0};
        vecs[13] = '{1'b1, 4'd7, 32'h70,        4'd7, 4'd9, 1'b0, 64'h0, 1'b1, 4'd7, 32'h70,    32'h99,    1'b1, 1'b0, HI1,   LO1,   16'h0080, 1'b1};
        vecs[14] = '{1'b0, 4'd0, 32'h0,         4'd7, 4'd0, 1'b0, 64'h0, 1'b0, 4'd0, 32'h70,    32'h0,     1'b1, 1'b0, HI1,   LO1,   16'h0080, 1'b0};
        vecs[15] = '{1'b1, 4'd0, 32'h1234_5678, 4'd7, 4'd0, 1'b0, 64'h0, 1'b0, 4'd0, 32'h70,    R0V,       1'b1, 1'b0, HI1,   LO1,   16'h0080, 1'b0};
        vecs[16] = '{1'b0, 4'd0, 32'h0,         4'd0, 4'd0, 1'b0, 64'h0, 1'b1, 4'd0, R0V,       R0V,       1'b0, 1'b0, HI1,   LO1,   16'h0080, 1'b0};
        vecs[17] = '{1'b0, 4'd0, 32'h0,         4'd0, 4'd7, 1'b0, 64'h0, 1'b1, 4'd0, R0V,       32'h70,    R0B,  1'b1, HI1,   LO1,   R0P,      1'b0};
        vecs[18] = '{1'b0, 4'd0, 32'h0,         4'd0, 4'd7, 1'b0, 64'h0, 1'b0, 4'd0, R0V,       32'h70,    R0B,  1'b1, HI1,   LO1,   R0P,      R0C};

        idle();
        raddr_a = 4'd1;
        raddr_b = 4'd2;
        clr = 1'b0;
        #12;
        check("reset rdata_a", rdata_a, 32'h0);
        check("reset rdata_b", rdata_b, 32'h0);
        check("reset hi_out", hi_out, 32'h0);
        check("reset lo_out", lo_out, 32'h0);
        check("reset pending", pending, 16'h0);
        check("reset wr_conflict", wr_conflict, 1'b0);
        clr = 1'b1;
        next_cycle();

        for (int i = 0; i < 19; i++) begin
            we = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd;
            raddr_a = vecs[i].ra; raddr_b = vecs[i].rb;
            hilo_we = vecs[i].hwe; hilo_wdata = vecs[i].hwd;
            busy_set = vecs[i].bs; busy_addr = vecs[i].ba;
            #1;
            check($sformatf("v%0d rdata_a", i), rdata_a, vecs[i].e_ra);
            check($sformatf("v%0d rdata_b", i), rdata_b, vecs[i].e_rb);
            check($sformatf("v%0d busy_a", i), busy_a, vecs[i].e_ba);
            check($sformatf("v%0d busy_b", i), busy_b, vecs[i].e_bb);
            check($sformatf("v%0d hi_out", i), hi_out, vecs[i].e_hi);
            check($sformatf("v%0d lo_out", i), lo_out, vecs[i].e_lo);
            check($sformatf("v%0d pending", i), pending, vecs[i].e_pend);
            check($sformatf("v%0d wr_conflict", i), wr_conflict, vecs[i].e_conf);
            next_cycle();
        end

        // Fill registers 1..15, then read each back through both ports.
        idle();
        for (int i = 1; i < 16; i++) begin
            we = 1'b1; waddr = 4'(i); wdata = 32'h0101_0101 * 32'(i);
            next_cycle();
        end
        idle();
        for (int i = 1; i < 16; i++) begin
            raddr_a = 4'(i);
            raddr_b = 4'(16 - i);
            #1;
            check($sformatf("readback a r%0d", i), rdata_a, 32'h0101_0101 * 32'(i));
            check($sformatf("readback b r%0d", 16 - i), rdata_b, 32'h0101_0101 * 32'(16 - i));
        end

        // Pending 2 and 9, then a repeat issue to 9 to leave wr_conflict high.
        busy_set = 1'b1; busy_addr = 4'd2;
        next_cycle();
        busy_addr = 4'd9;
        next_cycle();
        next_cycle();
        idle();
        raddr_a = 4'd9;
        raddr_b = 4'd2;
        #1;
        check("pre-reset pending", pending, 16'h0204 | (R0 ? 16'h0 : 16'h0001));
        check("pre-reset wr_conflict", wr_conflict, 1'b1);
        check("pre-reset busy_a", busy_a, 1'b1);

        #2;
        clr = 1'b0;
        #1;
        check("async reset rdata_a", rdata_a, 32'h0);
        check("async reset rdata_b", rdata_b, 32'h0);
        check("async reset busy_a", busy_a, 1'b0);
        check("async reset busy_b", busy_b, 1'b0);
        check("async reset hi_out", hi_out, 32'h0);
        check("async reset lo_out", lo_out, 32'h0);
        check("async reset pending", pending, 16'h0);
        check("async reset wr_conflict", wr_conflict, 1'b0);

        // Enables held during reset must not take effect; only the bypass is visible.
        we = 1'b1; waddr = 4'd4; wdata = 32'h0000_CAFE; raddr_a = 4'd4;
        hilo_we = 1'b1; hilo_wdata = HL;
        busy_set = 1'b1; busy_addr = 4'd4;
        #1;
        check("reset bypass rdata_a", rdata_a, 32'h0000_CAFE);
        next_cycle();
        idle();
        #1;
        check("reset ignore write", rdata_a, 32'h0);
        check("reset ignore hilo", hi_out, 32'h0);
        check("reset ignore busy", pending, 16'h0);

        #3;
        clr = 1'b1;
        next_cycle();
        we = 1'b1; waddr = 4'd4; wdata = 32'h0000_CAFE;
        busy_set = 1'b1; busy_addr = 4'd6;
        next_cycle();
        idle();
        raddr_a = 4'd4;
        raddr_b = 4'd6;
        #1;
        check("resume write", rdata_a, 32'h0000_CAFE);
        check("resume pending", pending, 16'h0040);
        check("resume busy_b", busy_b, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
